mem_data_port: RTL and testbench

- Responder side of the MEM-stage data interface: consumes MEM_RD, MEM_WR, w_h, DIR and DI as driven by the EX/MEM pipeline register, and performs the data-memory access.
- Holds the data-memory array and applies a configurable number of wait states.
- Returns read data on DO and drives mem_stall, which the hazard unit uses to deassert the pipeline enables while an access is in flight.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/mem_sram_1rw.sv | 38 +++
 rtl/mem_data_port.sv | 197 +++++++++++++++++++
 tb/tb_mem_data_port.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data port.
//   state_t    : access FSM encoding (IDLE / BUSY / DONE)
//   do_sel_t   : how DO is formed from the SRAM read register
//   SZ_WORD / SZ_HALF : encoding of the w_h access-size input
//   DEF_ADDR_W / DEF_WAIT_STATES : default geometry and timing
//   lane_mask() : byte-lane enable for a given size and halfword select
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // DO is rebuilt from the SRAM's held read word plus this selector, so a
  // faulty read or a reset can force DO to zero without touching the RAM.
  typedef enum logic [1:0] {
    DO_ZERO    = 2'b00,
    DO_WORD    = 2'b01,
    DO_HALF_LO = 2'b10,
    DO_HALF_HI = 2'b11
  } do_sel_t;

  localparam logic SZ_WORD = 1'b1;
  localparam logic SZ_HALF = 1'b0;

  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_WAIT_STATES = 1;

  function automatic logic [3:0] lane_mask(input logic size, input logic hi_half);
    if (size == SZ_HALF) begin
      return hi_half ? 4'b1100 : 4'b0011;
    end
    return 4'b1111;
  endfunction

endpackage

// File: rtl/mem_sram_1rw.sv
// Single-port synchronous word array with byte-write enables.
//   clk    : clock, rising edge
//   addr   : word address
//   be     : per-byte write enable (bit n writes wdata[8n+7:8n])
//   wdata  : write data
//   rd_en  : capture mem[addr] into the read register on this edge
//   rdata  : read register; holds its value until the next rd_en
// Contents are deliberately not reset so the array maps onto block RAM.
module mem_sram_1rw #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [31:0] mem_array [DEPTH];
  logic [31:0] rdata_reg;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        mem_array[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (rd_en) begin
      rdata_reg <= mem_array[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_data_port.sv
// Responder side of the MEM-stage data interface.
// Accepts a read or write from the EX/MEM register, spends WAIT_STATES
// extra cycles busy, then commits the access on the edge into DONE.
//   reloj       : clock, rising edge
//   resetMEM_n  : synchronous active-low reset
//   MEM_RD      : read request
//   MEM_WR      : write request
//   w_h         : access size, 1 = word, 0 = halfword
//   DIR         : byte address
//   DI          : write data (halfword data in DI[15:0])
//   DO          : read data, held between reads
//   dato_valido : one-cycle pulse in the DONE cycle
//   mem_stall   : high while an access is still in flight
//   addr_err    : one-cycle pulse with dato_valido for a faulty access
module mem_data_port
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic        reloj,
  input  logic        resetMEM_n,
  input  logic        MEM_RD,
  input  logic        MEM_WR,
  input  logic        w_h,
  input  logic [31:0] DIR,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        dato_valido,
  output logic        mem_stall,
  output logic        addr_err
);

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic        rd_lat_reg, wr_lat_reg, wh_lat_reg;
  logic [31:0] dir_lat_reg, di_lat_reg;

  do_sel_t     do_sel_reg;
  logic        dv_reg, err_reg;

  logic        request;
  logic        eff_rd, eff_wr, eff_wh;
  logic [31:0] eff_dir, eff_di;
  logic        misaligned, out_of_range, both_req, fault;
  logic        commit;

  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic              ram_rd_en;
  logic [31:0]       ram_rdata;

  assign request = MEM_RD | MEM_WR;

  // With WAIT_STATES=0 the commit edge is the accepting edge itself, so the
  // attributes must come straight from the inputs while still in IDLE.
  assign eff_rd  = (state_reg == IDLE) ? MEM_RD : rd_lat_reg;
  assign eff_wr  = (state_reg == IDLE) ? MEM_WR : wr_lat_reg;
  assign eff_wh  = (state_reg == IDLE) ? w_h    : wh_lat_reg;
  assign eff_dir = (state_reg == IDLE) ? DIR    : dir_lat_reg;
  assign eff_di  = (state_reg == IDLE) ? DI     : di_lat_reg;

  assign misaligned   = (eff_wh == SZ_WORD) ? (|eff_dir[1:0]) : eff_dir[0];
  assign out_of_range = (eff_dir >> (ADDR_W + 2)) != 32'd0;
  assign both_req     = eff_rd & eff_wr;
  assign fault        = misaligned | out_of_range | both_req;

  // Gating with resetMEM_n makes a reset during BUSY drop the pending write.
  assign commit = resetMEM_n &
                  (((state_reg == IDLE) & request & (WAIT_STATES == 0)) |
                   ((state_reg == BUSY) & (cnt_reg == CNT_W'(1))));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge reloj) begin
    if (!resetMEM_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (request) begin
          cnt_next   = CNT_W'(WAIT_STATES);
          state_next = (WAIT_STATES > 0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    if (resetMEM_n) begin
      case (state_reg)
        IDLE:    mem_stall = request;
        BUSY:    mem_stall = 1'b1;
        default: mem_stall = 1'b0;
      endcase
    end
  end

  // ------------------------------------------------- attribute capture
  always_ff @(posedge reloj) begin
    if (!resetMEM_n) begin
      rd_lat_reg  <= 1'b0;
      wr_lat_reg  <= 1'b0;
      wh_lat_reg  <= SZ_WORD;
      dir_lat_reg <= '0;
      di_lat_reg  <= '0;
    end else if ((state_reg == IDLE) && request) begin
      rd_lat_reg  <= MEM_RD;
      wr_lat_reg  <= MEM_WR;
      wh_lat_reg  <= w_h;
      dir_lat_reg <= DIR;
      di_lat_reg  <= DI;
    end
  end

  // ------------------------------------------------- completion flags
  always_ff @(posedge reloj) begin
    if (!resetMEM_n) begin
      dv_reg     <= 1'b0;
      err_reg    <= 1'b0;
      do_sel_reg <= DO_ZERO;
    end else begin
      dv_reg  <= commit;
      err_reg <= commit & fault;
      // Only reads move DO; a write leaves the previous read result in place.
      if (commit && eff_rd) begin
        if (fault) begin
          do_sel_reg <= DO_ZERO;
        end else if (eff_wh == SZ_WORD) begin
          do_sel_reg <= DO_WORD;
        end else begin
          do_sel_reg <= eff_dir[1] ? DO_HALF_HI : DO_HALF_LO;
        end
      end
    end
  end

  assign dato_valido = dv_reg;
  assign addr_err    = err_reg;

  // -------------------------------------------------- RAM interface
  assign ram_addr  = eff_dir[ADDR_W+1:2];
  assign ram_be    = (commit & eff_wr & ~fault) ? lane_mask(eff_wh, eff_dir[1]) : 4'b0000;
  assign ram_rd_en = commit & eff_rd & ~fault;

  // A halfword write replicates DI[15:0] onto both halves; the byte
  // enables then pick which half actually lands.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign ram_wdata[8*gi +: 8] = (eff_wh == SZ_WORD) ? eff_di[8*gi +: 8]
                                                        : eff_di[8*(gi % 2) +: 8];
    end
  endgenerate

  mem_sram_1rw #(
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk   (reloj),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rd_en (ram_rd_en),
    .rdata (ram_rdata)
  );

  always_comb begin
    DO = 32'd0;
    case (do_sel_reg)
      DO_WORD:    DO = ram_rdata;
      DO_HALF_LO: DO = {16'd0, ram_rdata[15:0]};
      DO_HALF_HI: DO = {16'd0, ram_rdata[31:16]};
      default:    DO = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mem_data_port.sv
// Directed bench for mem_data_port: one instance with one wait state and
// one with none, selected by 'sel'; the idle instance sees no requests.
module tb_mem_data_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd, wr, wh, sel;
  logic [31:0] dir, di;

  logic        rd1, wr1, rd0, wr0;
  logic [31:0] do1, do0;
  logic        dv1, dv0, st1, st0, er1, er0;

  logic [31:0] do_o;
  logic        dv_o, st_o, er_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rd1 = rd & sel;
  assign wr1 = wr & sel;
  assign rd0 = rd & ~sel;
  assign wr0 = wr & ~sel;

  assign do_o = sel ? do1 : do0;
  assign dv_o = sel ? dv1 : dv0;
  assign st_o = sel ? st1 : st0;
  assign er_o = sel ? er1 : er0;

  mem_data_port #(.ADDR_W(10), .WAIT_STATES(1)) dut_ws1 (
    .reloj(clk), .resetMEM_n(rst_n), .MEM_RD(rd1), .MEM_WR(wr1), .w_h(wh),
    .DIR(dir), .DI(di), .DO(do1), .dato_valido(dv1), .mem_stall(st1), .addr_err(er1)
  );

  mem_data_port #(.ADDR_W(10), .WAIT_STATES(0)) dut_ws0 (
    .reloj(clk), .resetMEM_n(rst_n), .MEM_RD(rd0), .MEM_WR(wr0), .w_h(wh),
    .DIR(dir), .DI(di), .DO(do0), .dato_valido(dv0), .mem_stall(st0), .addr_err(er0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one request right after a rising edge, holds it through DONE,
  // and reports stall cycles, cycles to dato_valido and the DONE-cycle outputs.
  task automatic access(input logic r, input logic w, input logic h,
                        input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output int lat,
                        output logic [31:0] dout, output logic err,
                        output logic done_stall);
    bit got;
    got = 1'b0; stalls = 0; lat = 0; dout = '0; err = 1'b0; done_stall = 1'b0;
    rd = r; wr = w; wh = h; dir = a; di = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (dv_o) begin
        got = 1'b1; dout = do_o; err = er_o; done_stall = st_o;
      end else begin
        if (st_o) stalls++;
        @(posedge clk); #1;
        lat++;
      end
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL timeout: observed no dato_valido expected pulse within 20 cycles");
    end
    $display("access rd=%0b wr=%0b wh=%0b dir=%h di=%h -> stalls=%0d lat=%0d do=%h err=%0b",
             r, w, h, a, d, stalls, lat, dout, err);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int          s, l, pulses;
    logic [31:0] q;
    logic        e, ds;

    rst_n = 1'b0; sel = 1'b1; rd = 1'b1; wr = 1'b0; wh = 1'b1;
    dir = 32'h10; di = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'd0, st_o}, 32'd0);
    chk("rst_do", do_o, 32'd0);
    chk("rst_dv", {31'd0, dv_o}, 32'd0);
    chk("rst_err", {31'd0, er_o}, 32'd0);
    chk("rst_do_ws0", do0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rd = 1'b0;
    @(posedge clk); #1;

    // Word write then read, one wait state
    access(0, 1, 1, 32'h10, 32'hDEADBEEF, s, l, q, e, ds);
    chk("wr_stalls", 32'(s), 32'd2);
    chk("wr_latency", 32'(l), 32'd2);
    chk("wr_err", {31'd0, e}, 32'd0);
    chk("wr_done_stall", {31'd0, ds}, 32'd0);
    access(1, 0, 1, 32'h10, 32'h0, s, l, q, e, ds);
    chk("rd_stalls", 32'(s), 32'd2);
    chk("rd_latency", 32'(l), 32'd2);
    chk("rd_data", q, 32'hDEADBEEF);
    chk("rd_err", {31'd0, e}, 32'd0);

    // Halfword lanes; the write must not disturb DO
    access(0, 1, 1, 32'h10, 32'h11223344, s, l, q, e, ds);
    chk("wr_keeps_do", q, 32'hDEADBEEF);
    access(0, 1, 0, 32'h12, 32'h0000CAFE, s, l, q, e, ds);
    chk("hw_wr_err", {31'd0, e}, 32'd0);
    access(1, 0, 1, 32'h10, 32'h0, s, l, q, e, ds);
    chk("hw_merge", q, 32'hCAFE3344);
    access(1, 0, 0, 32'h12, 32'h0, s, l, q, e, ds);
    chk("hw_rd_hi", q, 32'h0000CAFE);
    access(1, 0, 0, 32'h10, 32'h0, s, l, q, e, ds);
    chk("hw_rd_lo", q, 32'h00003344);

    // Misaligned read and out-of-range halfword write
    access(1, 0, 1, 32'h13, 32'h0, s, l, q, e, ds);
    chk("mis_err", {31'd0, e}, 32'd1);
    chk("mis_do", q, 32'd0);
    chk("mis_latency", 32'(l), 32'd2);
    access(0, 1, 1, 32'h0, 32'h01234567, s, l, q, e, ds);
    access(0, 1, 0, 32'h1000, 32'h0000BEEF, s, l, q, e, ds);
    chk("oor_err", {31'd0, e}, 32'd1);
    chk("oor_stalls", 32'(s), 32'd2);
    access(1, 0, 1, 32'h0, 32'h0, s, l, q, e, ds);
    chk("oor_mem_kept", q, 32'h01234567);
    chk("oor_rd_err", {31'd0, e}, 32'd0);

    // Reset during BUSY discards the pending write
    access(0, 1, 1, 32'h20, 32'h13579BDF, s, l, q, e, ds);
    access(1, 0, 1, 32'h20, 32'h0, s, l, q, e, ds);
    chk("pre_rst_rd", q, 32'h13579BDF);
    wr = 1'b1; wh = 1'b1; dir = 32'h20; di = 32'h55AA55AA;
    @(posedge clk);
    @(negedge clk);
    chk("busy_stall", {31'd0, st_o}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    wr = 1'b0;
    @(negedge clk);
    chk("busy_rst_stall", {31'd0, st_o}, 32'd0);
    chk("busy_rst_do", do_o, 32'd0);
    chk("busy_rst_dv", {31'd0, dv_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1, 0, 1, 32'h20, 32'h0, s, l, q, e, ds);
    chk("rst_write_dropped", q, 32'h13579BDF);

    // Simultaneous read and write
    access(0, 1, 1, 32'h8, 32'hA5A5A5A5, s, l, q, e, ds);
    access(1, 1, 1, 32'h8, 32'hFFFFFFFF, s, l, q, e, ds);
    chk("both_err", {31'd0, e}, 32'd1);
    chk("both_do", q, 32'd0);
    access(1, 0, 1, 32'h8, 32'h0, s, l, q, e, ds);
    chk("both_wr_supp", q, 32'hA5A5A5A5);

    // Zero wait states, back-to-back reads
    sel = 1'b0;
    access(0, 1, 1, 32'h0, 32'h0BADF00D, s, l, q, e, ds);
    access(0, 1, 1, 32'h4, 32'hFEEDFACE, s, l, q, e, ds);
    access(1, 0, 1, 32'h0, 32'h0, s, l, q, e, ds);
    chk("ws0_rd0_stalls", 32'(s), 32'd1);
    chk("ws0_rd0_latency", 32'(l), 32'd1);
    chk("ws0_rd0_data", q, 32'h0BADF00D);
    chk("ws0_rd0_done_stall", {31'd0, ds}, 32'd0);
    access(1, 0, 1, 32'h4, 32'h0, s, l, q, e, ds);
    chk("ws0_rd1_stalls", 32'(s), 32'd1);
    chk("ws0_rd1_latency", 32'(l), 32'd1);
    chk("ws0_rd1_data", q, 32'hFEEDFACE);
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (dv_o) pulses++;
    end
    chk("ws0_no_reaccept", 32'(pulses), 32'd0);
    chk("ws0_do_held", do_o, 32'hFEEDFACE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
